// File: rtl/instr_dec_pkg.sv
// Shared definitions for the instruction decoder slice.
//  - Field bit positions of a 32-bit MIPS-style instruction word.
//  - Opcode and function-code constants for the supported instruction set.
//  - Format encoding (R/I/J) and the packed record of decoded fields.
//  - classify(): maps an opcode to its instruction format.
package instr_dec_pkg;

  localparam int WL_C = 32;

  // Field positions (inclusive bit ranges)
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SH_HI    = 10;
  localparam int SH_LO    = 6;
  localparam int FN_HI    = 5;
  localparam int FN_LO    = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JT_HI    = 25;
  localparam int JT_LO    = 0;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LWL   = 6'h22;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LWR   = 6'h26;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function codes (R-type)
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_R    = 2'd1,
    FMT_I    = 2'd2,
    FMT_J    = 2'd3
  } fmt_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [31:0] imm_se;
    logic [25:0] jumpt;
    logic        is_r;
    logic        is_i;
    logic        is_j;
  } dec_t;

  // Every opcode that is neither R nor J falls into the I bucket,
  // including unsupported ones; legality is judged separately.
  function automatic fmt_e classify(input logic [5:0] op);
    fmt_e f;
    if (op == OP_RTYPE)                 f = FMT_R;
    else if (op == OP_J || op == OP_JAL) f = FMT_J;
    else                                f = FMT_I;
    return f;
  endfunction

endpackage

// File: rtl/instr_dec_if.sv
// Decoder bus: fetched instruction in, decoded fields out.
//  master : instruction source / field consumer (drives in_valid, Instr)
//  slave  : the decoder (drives out_valid, fields, format flags, illegal)
interface instr_dec_if;
  import instr_dec_pkg::*;

  logic        in_valid;
  logic [31:0] Instr;
  logic        out_valid;
  logic [5:0]  OPcode;
  logic [4:0]  RS;
  logic [4:0]  RT;
  logic [4:0]  RD;
  logic [4:0]  shamt;
  logic [5:0]  Func;
  logic [15:0] Imm;
  logic [31:0] ImmSE;
  logic [25:0] Jumpt;
  logic        is_r;
  logic        is_j;
  logic        is_i;
  logic        illegal;

  modport master (
    output in_valid, Instr,
    input  out_valid, OPcode, RS, RT, RD, shamt, Func, Imm, ImmSE, Jumpt,
           is_r, is_j, is_i, illegal
  );

  modport slave (
    input  in_valid, Instr,
    output out_valid, OPcode, RS, RT, RD, shamt, Func, Imm, ImmSE, Jumpt,
           is_r, is_j, is_i, illegal
  );
endinterface

// File: rtl/instr_dec_fields.sv
// instr_fields: purely combinational field slicer.
//  instr : 32-bit instruction word
//  dec   : all fields, sign-extended immediate and one-hot format flags
// Every field is extracted regardless of format.
module instr_fields
  import instr_dec_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  fmt_e fmt;

  always_comb begin
    fmt        = classify(instr[OP_HI:OP_LO]);
    dec        = '0;
    dec.opcode = instr[OP_HI:OP_LO];
    dec.rs     = instr[RS_HI:RS_LO];
    dec.rt     = instr[RT_HI:RT_LO];
    dec.rd     = instr[RD_HI:RD_LO];
    dec.shamt  = instr[SH_HI:SH_LO];
    dec.func   = instr[FN_HI:FN_LO];
    dec.imm    = instr[IMM_HI:IMM_LO];
    dec.imm_se = {{16{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
    dec.jumpt  = instr[JT_HI:JT_LO];
    dec.is_r   = (fmt == FMT_R);
    dec.is_i   = (fmt == FMT_I);
    dec.is_j   = (fmt == FMT_J);
  end

endmodule

// File: rtl/instr_dec.sv
// instr_dec: registered instruction field decoder.
//  CLK, RST : clock and synchronous active-high reset (clears every output)
//  bus      : instr_dec_if.slave -- in_valid/Instr in; out_valid, OPcode, RS,
//             RT, RD, shamt, Func, Imm, ImmSE, Jumpt, is_r/is_i/is_j, illegal out
// One cycle latency. Fields load only on in_valid and otherwise hold;
// out_valid follows in_valid every cycle.
// Optional feature macro: INSTRDEC_ILLEGAL_EN -- enables the unsupported
// opcode/function check; without it illegal is tied low.
module instr_dec
  import instr_dec_pkg::*;
#(
  parameter int WL = 32
)(
  input  logic        CLK,
  input  logic        RST,
  instr_dec_if.slave  bus
);

  if (WL != WL_C) begin : g_wl_chk
    $error("instr_dec: WL must be 32");
  end

  dec_t dec_p0;
  dec_t dec_p1;
  logic vld_p1;

  instr_fields u_fields (
    .instr (bus.Instr),
    .dec   (dec_p0)
  );

  // ---- stage p0 -> p1 : output register ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      dec_p1 <= '0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) dec_p1 <= dec_p0;
    end
  end

`ifdef INSTRDEC_ILLEGAL_EN
  logic ill_p1;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SW: ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic fn_supported(input logic [5:0] fn);
    logic ok;
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_JALR,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU: ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic ill_p0;
  always_comb begin
    ill_p0 = !op_supported(dec_p0.opcode);
    if (dec_p0.opcode == OP_RTYPE && !fn_supported(dec_p0.func)) ill_p0 = 1'b1;
  end

  // ---- stage p0 -> p1 : illegal flag, same load rule as the fields ----
  always_ff @(posedge CLK) begin
    if (RST)               ill_p1 <= 1'b0;
    else if (bus.in_valid) ill_p1 <= ill_p0;
  end

  assign bus.illegal = ill_p1;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.out_valid = vld_p1;
  assign bus.OPcode    = dec_p1.opcode;
  assign bus.RS        = dec_p1.rs;
  assign bus.RT        = dec_p1.rt;
  assign bus.RD        = dec_p1.rd;
  assign bus.shamt     = dec_p1.shamt;
  assign bus.Func      = dec_p1.func;
  assign bus.Imm       = dec_p1.imm;
  assign bus.ImmSE     = dec_p1.imm_se;
  assign bus.Jumpt     = dec_p1.jumpt;
  assign bus.is_r      = dec_p1.is_r;
  assign bus.is_i      = dec_p1.is_i;
  assign bus.is_j      = dec_p1.is_j;

endmodule

// File: tb/tb_instr_dec.sv
// Directed testbench for instr_dec.
module tb_instr_dec;

  logic CLK = 1'b0;
  logic RST;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  instr_dec_if bus ();

  instr_dec #(.WL(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.in_valid = 1'b1;
    bus.Instr = 32'hFFFF_FFFF;
    tick();
    tick();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got %0h want 0", bus.out_valid);
    end
    tests++;
    if ({bus.OPcode, bus.RS, bus.RT, bus.RD, bus.shamt, bus.Func} !== 32'h0) begin
      fails++; $display("FAIL reset_fields got op=%0h rs=%0d rt=%0d want 0", bus.OPcode, bus.RS, bus.RT);
    end
    tests++;
    if ({bus.Imm, bus.ImmSE, bus.Jumpt} !== 74'h0) begin
      fails++; $display("FAIL reset_imm got imm=%0h immse=%0h jt=%0h want 0", bus.Imm, bus.ImmSE, bus.Jumpt);
    end
    tests++;
    if ({bus.is_r, bus.is_i, bus.is_j, bus.illegal} !== 4'b0) begin
      fails++; $display("FAIL reset_flags got r=%b i=%b j=%b ill=%b want 0", bus.is_r, bus.is_i, bus.is_j, bus.illegal);
    end
    RST = 1'b0;
  endtask

  task automatic test_itype();
    bus.in_valid = 1'b1;
    bus.Instr = 32'h8AA9AB1A;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL itype_out_valid got %0h want 1", bus.out_valid);
    end
    tests++;
    if (bus.OPcode !== 6'h22 || bus.RS !== 5'd21 || bus.RT !== 5'd9) begin
      fails++; $display("FAIL itype_op_rs_rt got %0h %0d %0d want 22 21 9", bus.OPcode, bus.RS, bus.RT);
    end
    tests++;
    if (bus.RD !== 5'd21 || bus.shamt !== 5'd12 || bus.Func !== 6'h1A) begin
      fails++; $display("FAIL itype_rd_sh_fn got %0d %0d %0h want 21 12 1a", bus.RD, bus.shamt, bus.Func);
    end
    tests++;
    if (bus.Imm !== 16'hAB1A || bus.ImmSE !== 32'hFFFFAB1A) begin
      fails++; $display("FAIL itype_imm got %0h %0h want ab1a ffffab1a", bus.Imm, bus.ImmSE);
    end
    tests++;
    if (bus.Jumpt !== 26'h2A9AB1A) begin
      fails++; $display("FAIL itype_jumpt got %0h want 2a9ab1a", bus.Jumpt);
    end
    tests++;
    if ({bus.is_r, bus.is_i, bus.is_j, bus.illegal} !== 4'b0100) begin
      fails++; $display("FAIL itype_flags got %b want 0100", {bus.is_r, bus.is_i, bus.is_j, bus.illegal});
    end
  endtask

  task automatic test_hold();
    // Previous load was 0x8AA9AB1A; a different word with in_valid=0 must be ignored.
    bus.in_valid = 1'b0;
    bus.Instr = 32'h012A4020;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL hold_out_valid[%0d] got %0h want 0", i, bus.out_valid);
      end
      tests++;
      if (bus.OPcode !== 6'h22 || bus.ImmSE !== 32'hFFFFAB1A || bus.is_i !== 1'b1) begin
        fails++; $display("FAIL hold_fields[%0d] got op=%0h immse=%0h is_i=%b want 22 ffffab1a 1",
                          i, bus.OPcode, bus.ImmSE, bus.is_i);
      end
    end
  endtask

  task automatic test_rtype();
    bus.in_valid = 1'b1;
    bus.Instr = 32'h012A4020;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.OPcode !== 6'h00 || bus.RS !== 5'd9 || bus.RT !== 5'd10 || bus.RD !== 5'd8) begin
      fails++; $display("FAIL rtype_regs got op=%0h rs=%0d rt=%0d rd=%0d want 0 9 10 8",
                        bus.OPcode, bus.RS, bus.RT, bus.RD);
    end
    tests++;
    if (bus.Func !== 6'h20 || bus.shamt !== 5'd0 || bus.ImmSE !== 32'h00004020) begin
      fails++; $display("FAIL rtype_fn_imm got fn=%0h sh=%0d immse=%0h want 20 0 4020", bus.Func, bus.shamt, bus.ImmSE);
    end
    tests++;
    if ({bus.out_valid, bus.is_r, bus.is_i, bus.is_j, bus.illegal} !== 5'b11000) begin
      fails++; $display("FAIL rtype_flags got %b want 11000", {bus.out_valid, bus.is_r, bus.is_i, bus.is_j, bus.illegal});
    end
  endtask

  task automatic test_jtype();
    bus.in_valid = 1'b1;
    bus.Instr = 32'h0C100004;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.OPcode !== 6'h03 || bus.Jumpt !== 26'h0100004) begin
      fails++; $display("FAIL jal_fields got op=%0h jt=%0h want 3 100004", bus.OPcode, bus.Jumpt);
    end
    tests++;
    if ({bus.out_valid, bus.is_r, bus.is_i, bus.is_j} !== 4'b1001) begin
      fails++; $display("FAIL jal_flags got %b want 1001", {bus.out_valid, bus.is_r, bus.is_i, bus.is_j});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [5:0]  ops   [3];
    logic [31:0] imms  [3];
    logic [2:0]  fmts  [3];
    words = '{32'h20087FFF, 32'h08000010, 32'h00851022};
    ops   = '{6'h08, 6'h02, 6'h00};
    imms  = '{32'h00007FFF, 32'h00000010, 32'h00001022};
    fmts  = '{3'b010, 3'b001, 3'b100};
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.Instr = words[i];
      tick();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.OPcode !== ops[i] || bus.ImmSE !== imms[i]) begin
        fails++; $display("FAIL b2b_fields[%0d] got v=%b op=%0h immse=%0h want 1 %0h %0h",
                          i, bus.out_valid, bus.OPcode, bus.ImmSE, ops[i], imms[i]);
      end
      tests++;
      if ({bus.is_r, bus.is_i, bus.is_j} !== fmts[i]) begin
        fails++; $display("FAIL b2b_fmt[%0d] got %b want %b", i, {bus.is_r, bus.is_i, bus.is_j}, fmts[i]);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    bus.in_valid = 1'b1;
    bus.Instr = 32'h012A4020;
    tick();
    RST = 1'b1;
    bus.Instr = 32'h0C100004;
    tick();
    tests++;
    if ({bus.out_valid, bus.OPcode, bus.RS, bus.RT, bus.RD, bus.Func, bus.is_r, bus.is_i, bus.is_j} !== 30'h0) begin
      fails++; $display("FAIL midrst_clear got v=%b op=%0h rd=%0d fn=%0h r=%b want all 0",
                        bus.out_valid, bus.OPcode, bus.RD, bus.Func, bus.is_r);
    end
    RST = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tests++;
    if ({bus.out_valid, bus.OPcode, bus.Jumpt, bus.is_j} !== 34'h0) begin
      fails++; $display("FAIL midrst_dropped got v=%b op=%0h jt=%0h j=%b want 0",
                        bus.out_valid, bus.OPcode, bus.Jumpt, bus.is_j);
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.OPcode !== 6'h03 || bus.is_j !== 1'b1) begin
      fails++; $display("FAIL midrst_resume got v=%b op=%0h j=%b want 1 3 1", bus.out_valid, bus.OPcode, bus.is_j);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [3];
    logic        exp_ill [3];
    words = '{32'hFC000000, 32'h0000003F, 32'h8AA9AB1A};
`ifdef INSTRDEC_ILLEGAL_EN
    exp_ill = '{1'b1, 1'b1, 1'b0};
`else
    exp_ill = '{1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.Instr = words[i];
      tick();
      tests++;
      if (bus.illegal !== exp_ill[i]) begin
        fails++; $display("FAIL illegal[%0h] got %b want %b", words[i], bus.illegal, exp_ill[i]);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bus.in_valid = 1'b0;
    bus.Instr = 32'h0;
    test_reset();
    test_itype();
    test_hold();
    test_rtype();
    test_jtype();
    test_back_to_back();
    test_reset_midstream();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
